// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN skips the iteration when the quotient is trivial.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         flush,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_div;
  logic [W-1:0]   r_resp_data;
  logic           r_rem_op;
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_valid;

  logic           w_sgn;
  logic           w_neg_a;
  logic           w_neg_b;
  logic           w_bz;
  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic           w_early;
  logic           w_last;
  logic [W-1:0]   w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_q_fix;
  logic [W-1:0]   w_r_fix;

  assign w_sgn   = ~req_op[0];
  assign w_neg_a = w_sgn & req_a[W-1];
  assign w_neg_b = w_sgn & req_b[W-1];
  assign w_bz    = (req_b == '0);
  assign w_mag_a = w_neg_a ? -req_a : req_a;
  assign w_mag_b = w_neg_b ? -req_b : req_b;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_bz | (w_mag_a < w_mag_b);
`else
  assign w_early = 1'b0;
`endif

  // Partial remainder stays below 2^(W-1) before each shift, so W bits suffice.
  assign w_last   = (r_cnt == CW'(W - 1));
  assign w_rem_sh = {r_rem[W-2:0], r_q[W-1]};
  assign w_ge     = (w_rem_sh >= r_div);
  assign w_q_fix  = r_neg_q ? -r_q : r_q;
  assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_valid;
  assign resp_data  = r_resp_data;

  always_comb begin
    w_state_nx = r_state;
    if (flush) begin
      w_state_nx = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            w_state_nx = w_early ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (w_last) begin
            w_state_nx = S_FIX;
          end
        end
        S_FIX: begin
          w_state_nx = S_DONE;
        end
        S_DONE: begin
          if (r_valid & resp_ready) begin
            w_state_nx = S_IDLE;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_resp_data <= '0;
      r_rem_op    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_valid     <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cnt    <= '0;
            r_rem_op <= req_op[1];
            r_neg_q  <= (w_neg_a ^ w_neg_b) & ~w_bz;
            r_neg_r  <= w_neg_a;
            r_div    <= w_mag_b;
            if (w_early) begin
              r_q   <= w_bz ? '1 : '0;
              r_rem <= w_mag_a;
            end else begin
              r_q   <= w_mag_a;
              r_rem <= '0;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? (w_rem_sh - r_div) : w_rem_sh;
          r_q   <= {r_q[W-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_resp_data <= r_rem_op ? w_r_fix : w_q_fix;
        end
        S_DONE: begin
          // Data settles one cycle before valid rises.
          if (!r_valid) begin
            r_valid <= 1'b1;
          end else if (resp_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: scoreboard queue fed by the driver, popped by a monitor.
// Reference results come from plain signed/unsigned SV arithmetic.
module tb_div_iter;

  localparam int W = 32;

  logic         clk;
  logic         arstn;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;

  div_iter #(.W(W)) dut (
    .clk        (clk),
    .arstn      (arstn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  typedef struct {
    logic [31:0] d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cyc;
  int   n_rise;
  bit   bp_mode;
  bit   rr_fixed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s act=%08h exp=%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb_;
    logic [31:0] r;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    case (op)
      2'd0:    r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb_);
      2'd1:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    r = (b == 0) ? a : 32'(sa % sb_);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (b == 0 || ma < mb) return 2;
`endif
    return W + 2;
  endfunction

  task automatic monitor();
    bit          pv;
    logic [31:0] pd;
    pv = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (!arstn) begin
        pv = 1'b0;
      end else begin
        if (resp_valid && !pv) begin
          n_rise++;
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_resp", resp_data, 32'h0);
          end else begin
            chk((cyc - sb[0].acc) == sb[0].lat, "latency",
                32'(cyc - sb[0].acc), 32'(sb[0].lat));
          end
        end
        if (resp_valid && pv) begin
          chk(resp_data == pd, "data_stable", resp_data, pd);
          chk(!req_ready, "ready_low_in_done", 32'(req_ready), 32'h0);
        end
        if (resp_valid && resp_ready && sb.size() > 0) begin
          chk(resp_data == sb[0].d, "resp_data", resp_data, sb[0].d);
          sb.delete(0);
        end
        pv = resp_valid;
        pd = resp_data;
      end
    end
  endtask

  task automatic rr_drv();
    forever begin
      @(posedge clk);
      #1;
      resp_ready = bp_mode ? ($urandom_range(0, 1) == 1) : rr_fixed;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    bit   rdy;
    int   t;
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    t         = 0;
    do begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!rdy && t < 300);
    req_valid = 1'b0;
    if (!rdy) begin
      chk(1'b0, "accept_timeout", 32'(t), 32'h0);
    end else begin
      e.d   = exp;
      e.lat = ref_lat(op, a, b);
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      chk(1'b0, "drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [1:0]  t_op [11] = '{1, 3, 0, 2, 0, 2, 0, 2, 1, 0, 2};
  logic [31:0] t_a  [11] = '{100, 100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 7, 7,
                             32'hFFFF_FFFB, 32'hFFFF_FFFB, 9,
                             32'h8000_0000, 32'h8000_0000};
  logic [31:0] t_b  [11] = '{7, 7, 2, 2, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                             0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t_e  [11] = '{14, 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 1, 32'hFFFF_FFFF,
                             32'hFFFF_FFFB, 32'hFFFF_FFFF,
                             32'h8000_0000, 0};

  initial begin
    int          t;
    int          r0;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    n_rise     = 0;
    bp_mode    = 1'b0;
    rr_fixed   = 1'b1;
    arstn      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    fork
      monitor();
      rr_drv();
    join_none

    repeat (3) @(negedge clk);
    chk(req_ready == 1'b1, "rst_req_ready", 32'(req_ready), 32'h1);
    chk(resp_valid == 1'b0, "rst_resp_valid", 32'(resp_valid), 32'h0);
    chk(resp_data == '0, "rst_resp_data", resp_data, 32'h0);
    arstn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_e[i]);
    end
    drain();

    rr_fixed = 1'b0;
    issue(2'd1, 32'd1000, 32'd10, 32'd100);
    t = 0;
    while (!resp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(resp_valid == 1'b1, "bp_valid_seen", 32'(resp_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(!req_ready && resp_valid, "bp_hold", 32'({req_ready, resp_valid}),
          32'h1);
    end
    rr_fixed = 1'b1;
    @(negedge clk);
    chk(!req_ready && resp_valid, "bp_release_cycle",
        32'({req_ready, resp_valid}), 32'h1);
    @(negedge clk);
    chk(req_ready == 1'b1, "bp_ready_after", 32'(req_ready), 32'h1);
    issue(2'd3, 32'd1001, 32'd10, 32'd1);
    drain();

    issue(2'd1, 32'd1234, 32'd7, 32'd176);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    if (sb.size() > 0) sb.delete(0);
    @(negedge clk);
    chk(req_ready && !resp_valid, "flush_idle", 32'({req_ready, resp_valid}),
        32'h2);
    r0 = n_rise;
    repeat (45) @(posedge clk);
    chk(n_rise == r0, "flush_no_resp", 32'(n_rise), 32'(r0));

    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = 2'd1;
    req_a     = 32'd50;
    req_b     = 32'd5;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk(req_ready == 1'b1, "flush_rejects_req", 32'(req_ready), 32'h1);

    issue(2'd0, 32'hFFFF_FF00, 32'd3, 32'hFFFF_FFAB);
    repeat (5) @(posedge clk);
    #2 arstn = 1'b0;
    if (sb.size() > 0) sb.delete(0);
    #1;
    chk(req_ready && !resp_valid && resp_data == 0, "midrst_values",
        32'({req_ready, resp_valid}), 32'h2);
    @(negedge clk);
    arstn = 1'b1;
    r0 = n_rise;
    repeat (45) @(posedge clk);
    chk(n_rise == r0, "midrst_no_resp", 32'(n_rise), 32'(r0));
    issue(2'd1, 32'd50, 32'd5, 32'd10);
    drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      issue(op, a, b, ref_div(op, a, b));
    end
    drain();
    bp_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
